// File: rtl/aes_req_queue_if.sv
// Handshake bundle between the CPU-side job decoder, the AES request queue and the AES control FSM.
// The queue uses the slave modport; the producer/consumer side uses the master modport.
interface aes_req_queue_if #(
    parameter int unsigned ADDRW = 24,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned W  = 3 * ADDRW + 2;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          err_overflow;
    logic          err_clr;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready,
        output count,
        output err_overflow,
        input  err_clr
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready,
        input  count,
        output err_clr,
        input  err_overflow
    );
endinterface

// File: rtl/aes_req_queue.sv
// First-word-fall-through job FIFO feeding the AES control FSM.
// Entries are {mode, rsvd, key_addr, text_addr, dest_addr}; head is presented whenever non-empty.
module aes_req_queue #(
    parameter int unsigned ADDRW = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    aes_req_queue_if.slave  q
);
    localparam int unsigned W  = 3 * ADDRW + 2;
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [W-1:0]  r_mem [DEPTH];
    logic          r_err_overflow;

    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign w_wr_idx = r_wr_ptr[IW-1:0];
    assign w_rd_idx = r_rd_ptr[IW-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]);

    // in_ready depends only on stored state, so a same-cycle pop never opens a full queue.
    assign w_push = q.in_valid && !w_full;
    assign w_pop  = !w_empty && q.out_ready;
    assign w_drop = q.in_valid && w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Sticky overflow flag; a new drop wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_overflow <= 1'b0;
        end else if (w_drop) begin
            r_err_overflow <= 1'b1;
        end else if (q.err_clr) begin
            r_err_overflow <= 1'b0;
        end
    end

    // Storage is deliberately left unreset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_idx] <= q.in_data;
        end
    end

    assign q.in_ready     = !w_full;
    assign q.out_valid    = !w_empty;
    assign q.out_data     = w_empty ? '0 : r_mem[w_rd_idx];
    assign q.count        = r_wr_ptr - r_rd_ptr;
    assign q.err_overflow = r_err_overflow;

endmodule

// File: tb/tb_aes_req_queue.sv
// Directed bench for aes_req_queue: reset, single job, fill/overflow, streaming with wrap,
// full-plus-pop and mid-stream reset, all checked against hand-computed expectations.
module tb_aes_req_queue;
    localparam int unsigned ADDRW = 24;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 3 * ADDRW + 2;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    logic [W-1:0] jobs [16];
    logic [W-1:0] job_e;

    aes_req_queue_if #(.ADDRW(ADDRW), .DEPTH(DEPTH)) bus ();

    aes_req_queue #(.ADDRW(ADDRW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic mode, input logic [23:0] key,
                                        input logic [23:0] text, input logic [23:0] dest);
        return {mode, 1'b0, key, text, dest};
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) begin
            jobs[i] = mk(i[0], 24'h100000 + 24'(i), 24'h200000 + 24'(i), 24'h300000 + 24'(i));
        end
        job_e = mk(1'b1, 24'hEEEEEE, 24'hEEEEEE, 24'hEEEEEE);

        // 1: reset values, out_ready held high while empty
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus.err_clr   = 1'b0;
        #1;
        chk("rst_out_valid", 80'(bus.out_valid), 80'(0));
        chk("rst_in_ready", 80'(bus.in_ready), 80'(1));
        chk("rst_count", 80'(bus.count), 80'(0));
        chk("rst_err", 80'(bus.err_overflow), 80'(0));
        chk("rst_out_data", 80'(bus.out_data), 80'(0));
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("idle_out_valid", 80'(bus.out_valid), 80'(0));
        chk("idle_count", 80'(bus.count), 80'(0));

        // 2: single job, one-cycle latency then pop
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = mk(1'b1, 24'h000100, 24'h000200, 24'h000300);
        step();
        bus.in_valid = 1'b0;
        chk("single_valid", 80'(bus.out_valid), 80'(1));
        chk("single_data", 80'(bus.out_data), 80'({1'b1, 1'b0, 24'h000100, 24'h000200, 24'h000300}));
        chk("single_count", 80'(bus.count), 80'(1));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("single_pop_valid", 80'(bus.out_valid), 80'(0));
        chk("single_pop_count", 80'(bus.count), 80'(0));

        // 3: fill, overflow with simultaneous clear (set wins), drain, clear
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = jobs[i];
            step();
        end
        chk("full_count", 80'(bus.count), 80'(4));
        chk("full_in_ready", 80'(bus.in_ready), 80'(0));
        bus.in_data = job_e;
        bus.err_clr = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b0;
        chk("ovf_err", 80'(bus.err_overflow), 80'(1));
        chk("ovf_count", 80'(bus.count), 80'(4));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_data%0d", i), 80'(bus.out_data), 80'(jobs[i]));
            step();
        end
        bus.out_ready = 1'b0;
        chk("drain_empty", 80'(bus.out_valid), 80'(0));
        chk("drain_err_sticky", 80'(bus.err_overflow), 80'(1));
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("err_cleared", 80'(bus.err_overflow), 80'(0));

        // 4: concurrent push/pop at count 2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = jobs[i + 4];
            step();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_data = jobs[k + 6];
            chk($sformatf("conc_data%0d", k), 80'(bus.out_data), 80'(jobs[k + 4]));
            step();
            chk($sformatf("conc_count%0d", k), 80'(bus.count), 80'(2));
        end
        bus.in_valid = 1'b0;
        for (int k = 14; k < 16; k++) begin
            chk($sformatf("conc_tail%0d", k), 80'(bus.out_data), 80'(jobs[k]));
            step();
        end
        bus.out_ready = 1'b0;
        chk("conc_empty", 80'(bus.out_valid), 80'(0));

        // 5: full queue, pop and refused push in the same cycle
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = jobs[i + 8];
            step();
        end
        bus.in_data   = job_e;
        bus.out_ready = 1'b1;
        chk("fp_in_ready", 80'(bus.in_ready), 80'(0));
        step();
        bus.in_valid = 1'b0;
        chk("fp_count", 80'(bus.count), 80'(3));
        chk("fp_err", 80'(bus.err_overflow), 80'(1));
        for (int i = 9; i < 12; i++) begin
            chk($sformatf("fp_data%0d", i), 80'(bus.out_data), 80'(jobs[i]));
            step();
        end
        bus.out_ready = 1'b0;
        chk("fp_empty", 80'(bus.out_valid), 80'(0));
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;

        // 6: asynchronous reset at count 3, then first job after release comes out first
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = jobs[i + 1];
            step();
        end
        bus.in_valid = 1'b0;
        chk("mid_count", 80'(bus.count), 80'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 80'(bus.out_valid), 80'(0));
        chk("arst_count", 80'(bus.count), 80'(0));
        chk("arst_in_ready", 80'(bus.in_ready), 80'(1));
        step();
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = jobs[13];
        step();
        bus.in_data = jobs[14];
        step();
        bus.in_valid = 1'b0;
        chk("post_count", 80'(bus.count), 80'(2));
        chk("post_first", 80'(bus.out_data), 80'(jobs[13]));
        bus.out_ready = 1'b1;
        step();
        chk("post_second", 80'(bus.out_data), 80'(jobs[14]));
        step();
        bus.out_ready = 1'b0;
        chk("post_empty", 80'(bus.out_valid), 80'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
